// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel/line counters plus decoded sync, active and blanking strobes.
// Build option: define VGA_PIX_DIV_EN to advance one pixel every PIX_DIV clocks instead of every clock.
module vga_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int PIX_DIV  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       h_sync,
    output logic       v_sync,
    output logic       active,
    output logic       blanking_start,
    output logic       pix_ce
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT        = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT        = 10'(V_ACTIVE);
    localparam logic [9:0] V_ACT_LAST   = 10'(V_ACTIVE - 1);
    localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] r_x;
    logic [9:0] r_y;
    logic       w_pix_ce;

`ifdef VGA_PIX_DIV_EN
    localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

    logic [DIV_W-1:0] r_div;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (r_div == DIV_LAST) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    assign w_pix_ce = (r_div == DIV_LAST);
`else
    assign w_pix_ce = 1'b1;
`endif

    // y only moves on the pixel that wraps x, so a frame ends exactly at (H_LAST, V_LAST).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_pix_ce) begin
            if (r_x == H_LAST) begin
                r_x <= '0;
                r_y <= (r_y == V_LAST) ? '0 : r_y + 10'd1;
            end else begin
                r_x <= r_x + 10'd1;
            end
        end
    end

    assign x              = r_x;
    assign y              = r_y;
    assign pix_ce         = w_pix_ce;
    assign active         = (r_x < H_ACT) && (r_y < V_ACT);
    assign h_sync         = !((r_x >= H_SYNC_START) && (r_x < H_SYNC_END));
    assign v_sync         = !((r_y >= V_SYNC_START) && (r_y < V_SYNC_END));
    assign blanking_start = (r_x == H_ACT) && (r_y == V_ACT_LAST);
endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a shrunken-timing instance checked cycle by cycle against a
// reference raster model, plus a default-timing instance checked over one full line.
module tb_vga_sync_gen;
    localparam int HA = 16, HF = 4, HS = 6, HB = 4;
    localparam int VA = 12, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
`ifdef VGA_PIX_DIV_EN
    localparam int PD = 2;
`else
    localparam int PD = 1;
`endif
    localparam int FRAME = HT * VT * PD;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] x, y, dx, dy;
    logic       hs, vs, act, bs, ce;
    logic       dhs, dvs, dact, dbs, dce;

    vga_sync_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .PIX_DIV(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .h_sync(hs), .v_sync(vs),
        .active(act), .blanking_start(bs), .pix_ce(ce)
    );

    vga_sync_gen dut_def (
        .clk(clk), .rst_n(rst_n), .x(dx), .y(dy), .h_sync(dhs), .v_sync(dvs),
        .active(dact), .blanking_start(dbs), .pix_ce(dce)
    );

    always #5 clk = ~clk;

    typedef logic [24:0] exp_t;
    exp_t q[$];

    int total = 0;
    int bad = 0;
    int mx = 0, my = 0, mdiv = 0;
    int cyc = 0;
    // frame window bookkeeping (between two blanking_start rising edges)
    int fstate = 0, fstart = 0, period = -1, bs_cnt = 0, vs_cnt = 0, ywrap = 0;
    logic prev_bs = 1'b0;
    logic [9:0] prev_y = '0;
    // default-timing line bookkeeping
    int def_hs_low = 0, def_hs_first = -1, def_wrapped = 0;
    logic [9:0] prev_dx = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t expect_of(input int ex, input int ey, input int ediv);
        logic ece, ehs, evs, eact, ebs;
        ece  = (PD == 1) ? 1'b1 : (ediv == PD - 1);
        ehs  = !(ex >= HA + HF && ex < HA + HF + HS);
        evs  = !(ey >= VA + VF && ey < VA + VF + VS);
        eact = (ex < HA) && (ey < VA);
        ebs  = (ex == HA) && (ey == VA - 1);
        return {10'(ex), 10'(ey), ehs, evs, eact, ebs, ece};
    endfunction

    task automatic tick();
        exp_t e, o;
        logic mce;
        @(posedge clk);
        cyc++;
        if (rst_n) begin
            mce = (PD == 1) || (mdiv == PD - 1);
            if (mce) begin
                if (mx == HT - 1) begin
                    mx = 0;
                    my = (my == VT - 1) ? 0 : my + 1;
                end else begin
                    mx = mx + 1;
                end
            end
            mdiv = (mdiv == PD - 1) ? 0 : mdiv + 1;
        end
        q.push_back(expect_of(mx, my, mdiv));
        #1;
        e = q.pop_front();
        o = {x, y, hs, vs, act, bs, ce};
        check($sformatf("cyc%0d_x%0d_y%0d", cyc, mx, my), 32'(o), 32'(e));

        if (bs && !prev_bs) begin
            if (fstate == 0) begin
                fstate = 1;
                fstart = cyc;
            end else if (fstate == 1) begin
                fstate = 2;
                period = cyc - fstart;
            end
        end
        if (fstate == 1) begin
            if (bs) bs_cnt++;
            if (!vs) vs_cnt++;
        end
        if (prev_y == 10'(VT - 1) && y == 10'd0) ywrap++;
        prev_bs = bs;
        prev_y  = y;

        if (rst_n && def_wrapped == 0) begin
            if (!dhs) begin
                def_hs_low++;
                if (def_hs_first < 0) def_hs_first = int'(dx);
            end
            if (prev_dx == 10'd799 && dx == 10'd0) begin
                def_wrapped = 1;
                check("def_y_increment", 32'(dy), 32'd1);
            end
        end
        prev_dx = dx;
    endtask

    initial begin
        // hold reset across several edges, then check the reset decode
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_state", 32'({x, y, hs, vs, act, bs}), 32'({10'd0, 10'd0, 4'b1110}));
        check("rst_pix_ce", 32'(ce), 32'((PD == 1) ? 1 : 0));
        check("rst_def_state", 32'({dx, dy, dhs, dvs, dact, dbs}), 32'({10'd0, 10'd0, 4'b1110}));

        rst_n = 1'b1;
        repeat (5) tick();
        check("x_after_5clk", 32'(x), 32'(5 / PD));

        // one full default line: h_sync width/position and the x wrap
        repeat (800 * PD) tick();
        check("def_line_wrapped", 32'(def_wrapped), 32'd1);
        check("def_hs_first_x", 32'(def_hs_first), 32'd656);
        check("def_hs_low_clks", 32'(def_hs_low), 32'(96 * PD));

        // frame window on the small instance
        for (int i = 0; i < 2 * FRAME + HT * PD && fstate != 2; i++) tick();
        check("frame_period", 32'(period), 32'(FRAME));
        check("bs_clks_per_frame", 32'(bs_cnt), 32'(PD));
        check("vs_low_clks", 32'(vs_cnt), 32'(VS * HT * PD));
        check("y_wrapped", 32'(ywrap > 0), 32'd1);

        // run into the horizontal sync region of a middle line, then reset asynchronously
        for (int i = 0; i < 2 * FRAME && !(mx == HA + HF + 1 && my == 7); i++) tick();
        check("reached_mid_frame", 32'({10'(mx), 10'(my)}), 32'({10'(HA + HF + 1), 10'd7}));
        check("hs_low_mid_frame", 32'(hs), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_xy", 32'({x, y}), 32'd0);
        check("async_rst_hs", 32'(hs), 32'd1);
        check("async_rst_def_x", 32'(dx), 32'd0);
        mx = 0;
        my = 0;
        mdiv = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4 * PD) tick();
        check("restart_x", 32'({x, y}), 32'({10'd4, 10'd0}));
        repeat (HT * PD) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
